// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing, coordinate width and the {hs, vs, active}
// sync bundle passed between the raster decode and the alignment delay line.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int   COORD_W      = 13;
  localparam logic SYNC_ACT_DEF = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  // Bundle value for "no sync pulse, blanked" at the given sync polarity.
  function automatic sync_t sync_idle(logic sync_act);
    sync_t s;
    s.hs     = ~sync_act;
    s.vs     = ~sync_act;
    s.active = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// PIPE_LAT-deep shift register for the sync bundle, advancing only on pix_en,
// so sync/blank line up with the processor's returned pixel.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int   PIPE_LAT = 1,
  parameter logic SYNC_ACT = SYNC_ACT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [2:0] sync_in,
  output logic [2:0] sync_out
);

  localparam logic [2:0] IDLE = sync_idle(SYNC_ACT);

  generate
    if (PIPE_LAT == 0) begin : g_wire
      assign sync_out = sync_in;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_LAT];
      logic [2:0] pipe_d [PIPE_LAT];

      always_comb begin
        for (int i = 0; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i];
        if (pix_en) begin
          pipe_d[0] = sync_in;
          for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= IDLE;
        end else begin
          for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign sync_out = pipe_q[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters with registered sync/blank decode, plus re-alignment of the
// pixel processor's returned RGB with delayed sync/blank for the VGA DAC.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   PIPE_LAT = 1,
  parameter logic SYNC_ACT = SYNC_ACT_DEF,
  parameter int   H_ACT    = H_ACTIVE,
  parameter int   H_FRONT  = H_FP,
  parameter int   H_SYNC_W = H_SYNC,
  parameter int   H_BACK   = H_BP,
  parameter int   V_ACT    = V_ACTIVE,
  parameter int   V_FRONT  = V_FP,
  parameter int   V_SYNC_W = V_SYNC,
  parameter int   V_BACK   = V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [7:0]         i_R,
  input  logic [7:0]         i_G,
  input  logic [7:0]         i_B,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic               o_VS_raw,
  output logic               o_frame_start,
  output logic               o_VGA_HS,
  output logic               o_VGA_VS,
  output logic               o_VGA_BLANK_N,
  output logic [7:0]         o_VGA_R,
  output logic [7:0]         o_VGA_G,
  output logic [7:0]         o_VGA_B
);

  localparam int HT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(VT - 1);
  localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACT);
  localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACT);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACT + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_ACT + H_FRONT + H_SYNC_W);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACT + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_ACT + V_FRONT + V_SYNC_W);

  function automatic sync_t decode(logic [COORD_W-1:0] col, logic [COORD_W-1:0] row);
    sync_t s;
    s.hs     = ((col >= HS_BEG) && (col < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    s.vs     = ((row >= VS_BEG) && (row < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    s.active = (col < H_ACT_C) && (row < V_ACT_C);
    return s;
  endfunction

  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  sync_t              sync_q, sync_d, dly;
  logic [2:0]         dly_bits;
  logic               hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [23:0]        rgb_q, rgb_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Decoding the next-state counters keeps the flags aligned with o_row/o_col.
  assign sync_d = decode(col_d, row_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      sync_q <= decode('0, '0);
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      sync_q <= sync_d;
    end
  end

  vga_sync_delay #(
    .PIPE_LAT (PIPE_LAT),
    .SYNC_ACT (SYNC_ACT)
  ) u_sync_delay (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .sync_in  (sync_q),
    .sync_out (dly_bits)
  );

  assign dly = sync_t'(dly_bits);

  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_en) begin
      hs_d      = dly.hs;
      vs_d      = dly.vs;
      blank_n_d = dly.active;
      rgb_d     = dly.active ? {i_R, i_G, i_B} : 24'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= ~SYNC_ACT;
      vs_q      <= ~SYNC_ACT;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_VS_raw      = sync_q.vs;
  assign o_frame_start = pix_en & ~reset & (row_q == '0) & (col_q == '0);
  assign o_VGA_HS      = hs_q;
  assign o_VGA_VS      = vs_q;
  assign o_VGA_BLANK_N = blank_n_q;
  assign o_VGA_R       = rgb_q[23:16];
  assign o_VGA_G       = rgb_q[15:8];
  assign o_VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a reduced-raster instance (PIPE_LAT=2, processor model fed back) and a
// full 640x480 instance (PIPE_LAT=1), both checked against an arithmetic raster model.
module tb_vga_timing_gen;

  // reduced raster: 40 x 19, frame = 760 pixels
  localparam int S_HA = 24, S_HF = 4, S_HSW = 6, S_HB = 6;
  localparam int S_VA = 12, S_VF = 2, S_VSW = 2, S_VB = 3;
  localparam int S_HT = 40, S_VT = 19, S_LAT = 2;
  localparam int F_HT = 800, F_VT = 525, F_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic ff_mode = 1'b0;
  logic started = 1'b0;

  logic [7:0]  s_r, s_g, s_b, f_in;
  logic [12:0] s_row, s_col, f_row, f_col;
  logic        s_vs_raw, s_fs, s_hs, s_vs, s_blank;
  logic        f_vs_raw, f_fs, f_hs, f_vs, f_blank;
  logic [7:0]  s_or, s_og, s_ob, f_or, f_og, f_ob;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint p = 0;
  logic [23:0] st1 = '0, st2 = '0;
  logic [7:0]  b_cur = 8'h5A;
  logic        hist_ff [16];
  logic [7:0]  hist_b  [16];

  int     fs_cnt = 0;
  longint fs_last = -1, fs_gap = -1;
  logic   prev_hs_f = 1'b1, prev_vs_s = 1'b1;
  longint hs_fall = 0, hs_gap = -1, hs_width = -1, hs_fall_col = -1;
  longint vs_fall = 0, vs_gap = -1, vs_width = -1;

  assign f_in = 8'hFF;
  assign s_r = st2[23:16];
  assign s_g = st2[15:8];
  assign s_b = st2[7:0];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .PIPE_LAT (S_LAT), .SYNC_ACT (1'b0),
    .H_ACT (S_HA), .H_FRONT (S_HF), .H_SYNC_W (S_HSW), .H_BACK (S_HB),
    .V_ACT (S_VA), .V_FRONT (S_VF), .V_SYNC_W (S_VSW), .V_BACK (S_VB)
  ) dut_s (
    .clk (clk), .reset (reset), .pix_en (pix_en),
    .i_R (s_r), .i_G (s_g), .i_B (s_b),
    .o_row (s_row), .o_col (s_col), .o_VS_raw (s_vs_raw), .o_frame_start (s_fs),
    .o_VGA_HS (s_hs), .o_VGA_VS (s_vs), .o_VGA_BLANK_N (s_blank),
    .o_VGA_R (s_or), .o_VGA_G (s_og), .o_VGA_B (s_ob)
  );

  vga_timing_gen dut_f (
    .clk (clk), .reset (reset), .pix_en (pix_en),
    .i_R (f_in), .i_G (f_in), .i_B (f_in),
    .o_row (f_row), .o_col (f_col), .o_VS_raw (f_vs_raw), .o_frame_start (f_fs),
    .o_VGA_HS (f_hs), .o_VGA_VS (f_vs), .o_VGA_BLANK_N (f_blank),
    .o_VGA_R (f_or), .o_VGA_G (f_og), .o_VGA_B (f_ob)
  );

  function automatic int col_of(longint q, int ht, int vt);
    return int'((q % longint'(ht * vt)) % longint'(ht));
  endfunction

  function automatic int row_of(longint q, int ht, int vt);
    return int'((q % longint'(ht * vt)) / longint'(ht));
  endfunction

  // {hs level, vs level, active} for pixel q, active-low syncs
  function automatic logic [2:0] flags(longint q, int ht, int vt, int ha, int hsb, int hse,
                                       int va, int vsb, int vse);
    int c, r;
    c = col_of(q, ht, vt);
    r = row_of(q, ht, vt);
    return {!(c >= hsb && c < hse), !(r >= vsb && r < vse), (c < ha && r < va)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // pixel-processor model (latency 2) plus pixel index bookkeeping
  always @(posedge clk) begin
    if (reset) begin
      p <= 0;
    end else if (pix_en) begin
      st1 <= ff_mode ? 24'hFFFFFF : {s_col[7:0], s_row[7:0], b_cur};
      st2 <= st1;
      hist_ff[int'(p % 16)] <= ff_mode;
      hist_b[int'(p % 16)]  <= b_cur;
      b_cur <= 8'($urandom);
      p <= p + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0]  fl;
    logic [23:0] rgb;
    longint      q;
    logic [7:0]  c8, r8;
    cyc++;
    if (started) begin
      if (reset) begin
        chk("s_fs_in_reset", s_fs, 0);
        chk("f_fs_in_reset", f_fs, 0);
      end else begin
        chk("s_col", s_col, col_of(p, S_HT, S_VT));
        chk("s_row", s_row, row_of(p, S_HT, S_VT));
        fl = flags(p, S_HT, S_VT, S_HA, 28, 34, S_VA, 14, 16);
        chk("s_vs_raw", s_vs_raw, fl[1]);
        chk("s_frame_start", s_fs, (pix_en && (p % 760 == 0)) ? 1 : 0);
        fl = 3'b110;
        rgb = '0;
        if (p >= S_LAT + 1) begin
          q = p - (S_LAT + 1);
          fl = flags(q, S_HT, S_VT, S_HA, 28, 34, S_VA, 14, 16);
          c8 = 8'(col_of(q, S_HT, S_VT));
          r8 = 8'(row_of(q, S_HT, S_VT));
          if (fl[0]) rgb = hist_ff[int'(q % 16)] ? 24'hFFFFFF : {c8, r8, hist_b[int'(q % 16)]};
        end
        chk("s_hs", s_hs, fl[2]);
        chk("s_vs", s_vs, fl[1]);
        chk("s_blank_n", s_blank, fl[0]);
        chk("s_rgb", {s_or, s_og, s_ob}, rgb);

        chk("f_col", f_col, col_of(p, F_HT, F_VT));
        chk("f_row", f_row, row_of(p, F_HT, F_VT));
        fl = flags(p, F_HT, F_VT, 640, 656, 752, 480, 490, 492);
        chk("f_vs_raw", f_vs_raw, fl[1]);
        chk("f_frame_start", f_fs, (pix_en && (p % 420000 == 0)) ? 1 : 0);
        fl = 3'b110;
        if (p >= F_LAT + 1) fl = flags(p - (F_LAT + 1), F_HT, F_VT, 640, 656, 752, 480, 490, 492);
        chk("f_hs", f_hs, fl[2]);
        chk("f_vs", f_vs, fl[1]);
        chk("f_blank_n", f_blank, fl[0]);
        chk("f_rgb", {f_or, f_og, f_ob}, fl[0] ? 24'hFFFFFF : 24'h0);

        if (s_fs) begin
          fs_cnt++;
          if (fs_last >= 0) fs_gap = cyc - fs_last;
          fs_last = cyc;
        end
        if (prev_hs_f && !f_hs) begin
          hs_gap = cyc - hs_fall; hs_fall = cyc; hs_fall_col = f_col;
        end
        if (!prev_hs_f && f_hs) hs_width = cyc - hs_fall;
        if (prev_vs_s && !s_vs) begin
          vs_gap = cyc - vs_fall; vs_fall = cyc;
        end
        if (!prev_vs_s && s_vs) vs_width = cyc - vs_fall;
      end
      prev_hs_f = f_hs;
      prev_vs_s = s_vs;
    end
  end

  task automatic step(input logic en, input logic rst);
    @(posedge clk);
    #1;
    pix_en = en;
    reset  = rst;
  endtask

  initial begin
    int base, guard;
    step(1'b0, 1'b1);
    started = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("rst_row", s_row, 0);
    chk("rst_col", s_col, 0);
    chk("rst_hs", s_hs, 1);
    chk("rst_vs", s_vs, 1);
    chk("rst_blank_n", s_blank, 0);
    chk("rst_r", s_or, 0);

    // first enabled cycle after reset: pixel (0,0), frame_start fires
    base = fs_cnt;
    step(1'b1, 1'b0);
    @(negedge clk); chk("first_fs", s_fs, 1);
    step(1'b1, 1'b0);
    @(negedge clk); chk("second_col", s_col, 1); chk("second_fs", s_fs, 0);
    step(1'b1, 1'b0);
    @(negedge clk); chk("blank_before_first_px", s_blank, 0);
    step(1'b1, 1'b0);
    @(negedge clk); chk("blank_first_px", s_blank, 1); chk("r_first_px", s_or, 0);
    step(1'b1, 1'b0);
    @(negedge clk); chk("r_second_px", s_or, 1);
    repeat (2275) step(1'b1, 1'b0);
    @(negedge clk); #1;
    chk("fs_count_3_frames", fs_cnt - base, 3);
    chk("fs_spacing", fs_gap, 760);

    ff_mode = 1'b1;
    repeat (1000) step(1'b1, 1'b0);
    ff_mode = 1'b0;

    for (int i = 0; i < 5000; i++) step((i % 2) == 0, 1'b0);
    @(negedge clk); #1;
    chk("hs_period_half_rate", hs_gap, 1600);
    chk("hs_width_half_rate", hs_width, 192);

    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0, 1'b0);

    // reset mid-frame at small raster (row 7, col 10)
    guard = 0;
    step(1'b1, 1'b0);
    while ((p % 760) != 290 && guard < 2000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("wait_row7_col10_timeout", (guard < 2000) ? 1 : 0, 1);
    reset = 1'b1;
    step(1'b1, 1'b0);
    @(negedge clk);
    chk("mid_rst_row", s_row, 0);
    chk("mid_rst_col", s_col, 0);
    chk("mid_rst_hs", s_hs, 1);
    chk("mid_rst_vs", s_vs, 1);
    chk("mid_rst_blank_n", s_blank, 0);
    chk("mid_rst_rgb", {s_or, s_og, s_ob}, 0);
    chk("mid_rst_fs", s_fs, 1);

    repeat (50000) step(1'b1, 1'b0);
    @(negedge clk); #1;
    chk("hs_period", hs_gap, 800);
    chk("hs_width", hs_width, 96);
    chk("hs_fall_col", hs_fall_col, 658);
    chk("small_vs_period", vs_gap, 760);
    chk("small_vs_width", vs_width, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
